// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider with width/sign parameters and result flags.
// Optional DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_seq_param #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             is_ovf;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign sign_a = (SIGNED != 0) & dividend[WIDTH-1];
  assign sign_b = (SIGNED != 0) & divisor[WIDTH-1];
  assign mag_a  = sign_a ? -dividend : dividend;
  assign mag_b  = sign_b ? -divisor : divisor;
  assign is_ovf = (SIGNED != 0)
                & (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                & (divisor == {WIDTH{1'b1}});

  // Extra top bit keeps the trial subtract's borrow visible.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovfp_d  = ovfp_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = mag_a;
          dvs_d  = mag_b;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH-1);
          negq_d = sign_a ^ sign_b;
          negr_d = sign_a;
          ovfp_d = is_ovf;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            res_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (mag_a < mag_b) begin
            quo_d   = '0;
            res_d   = dividend;
            state_d = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy    = 1'b1;
        quo_d   = negq_q ? -dvd_q : dvd_q;
        res_d   = negr_q ? -rem_q[WIDTH-1:0]
                         : rem_q[WIDTH-1:0];
        ovf_d   = ovfp_q;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovfp_q  <= ovfp_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: one unsigned and one signed instance,
// 16-bit, directed vectors with hand-computed results.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;
  logic        busy0, done0, dbz0, ovf0;
  logic        busy1, done1, dbz1, ovf1;
  logic [15:0] q0, r0, q1, r1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  div_seq_param #(.WIDTH(16), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .dividend(dvd0), .divisor(dvs0),
    .busy(busy0), .done(done0),
    .quotient(q0), .remainder(r0),
    .div_by_zero(dbz0), .overflow(ovf0)
  );

  div_seq_param #(.WIDTH(16), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .dividend(dvd1), .divisor(dvs1),
    .busy(busy1), .done(done1),
    .quotient(q1), .remainder(r1),
    .div_by_zero(dbz1), .overflow(ovf1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [15:0] q,
                     input logic [15:0] r, input logic dbz,
                     input logic ovf);
    chk({e.nm, " quotient"}, 32'(q), 32'(e.q));
    chk({e.nm, " remainder"}, 32'(r), 32'(e.r));
    chk({e.nm, " div_by_zero"}, 32'(dbz), 32'(e.dbz));
    chk({e.nm, " overflow"}, 32'(ovf), 32'(e.ovf));
    chk({e.nm, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (rst && done0) begin
      if (sb0.size() == 0) begin
        chk("unexpected done u0", 32'(1), 32'(0));
      end else begin
        cmp(sb0.pop_front(), q0, r0, dbz0, ovf0);
      end
    end
    if (rst && done1) begin
      if (sb1.size() == 0) begin
        chk("unexpected done u1", 32'(1), 32'(0));
      end else begin
        cmp(sb1.pop_front(), q1, r1, dbz1, ovf1);
      end
    end
  end

  task automatic issue(input int dut, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input logic edbz,
                       input logic eovf, input int lat,
                       input string nm, input bit push);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    e.acc = cyc + 1; e.lat = lat; e.nm = nm;
    if (dut == 0) begin
      start0 = 1'b1; dvd0 = a; dvs0 = b;
      if (push) sb0.push_back(e);
    end else begin
      start1 = 1'b1; dvd1 = a; dvs1 = b;
      if (push) sb1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    dvd0 = 16'hA5A5; dvs0 = 16'h5A5A;
    dvd1 = 16'hA5A5; dvs1 = 16'h5A5A;
  endtask

  task automatic wait_done(input int dut, input string nm,
                           output int nbusy);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((dut == 0) ? done0 : done1) begin
        seen = 1'b1;
      end else begin
        if ((dut == 0) ? busy0 : busy1) nbusy++;
        @(negedge clk);
      end
    end
    chk({nm, " done seen"}, 32'(seen), 32'(1));
    @(negedge clk);
  endtask

  task automatic run(input int dut, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] eq,
                     input logic [15:0] er, input logic edbz,
                     input logic eovf, input int lat,
                     input string nm);
    int nb;
    issue(dut, a, b, eq, er, edbz, eovf, lat, nm, 1'b1);
    wait_done(dut, nm, nb);
    chk({nm, " busy cycles"}, 32'(nb), 32'(lat - 1));
  endtask

  localparam int EE_LAT =
`ifdef DIV_EARLY_EXIT_EN
    1;
`else
    18;
`endif

  initial begin
    int nb;
    #1;
    chk("reset busy", 32'(busy0), 32'(0));
    chk("reset done", 32'(done0), 32'(0));
    chk("reset quotient", 32'(q0), 32'(0));
    chk("reset remainder", 32'(r0), 32'(0));
    chk("reset flags", 32'({dbz0, ovf0, dbz1, ovf1}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 18, "u 1000/7");
    run(0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1,
        "u 0x1234/0");
    run(0, 16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 1'b0, 18, "u 20/4");
    run(0, 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b0, 18,
        "u ffff/ffff");
    run(0, 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 1'b0, EE_LAT, "u 3/10");

    issue(0, 16'd50, 16'd3, 16'd16, 16'd2, 1'b0, 1'b0, 18,
          "u 50/3 ignore", 1'b1);
    repeat (3) @(negedge clk);
    start0 = 1'b1; dvd0 = 16'd9; dvs0 = 16'd9;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, "u 50/3 ignore", nb);

    issue(0, 16'd200, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 18,
          "u abort", 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy0), 32'(0));
    chk("abort done", 32'(done0), 32'(0));
    chk("abort quotient", 32'(q0), 32'(0));
    chk("abort remainder", 32'(r0), 32'(0));
    chk("abort flags", 32'({dbz0, ovf0}), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    run(0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b0, 18, "u 100/10");

    run(1, 16'hFFEF, 16'd5, 16'hFFFD, 16'hFFFE, 1'b0, 1'b0, 18,
        "s -17/5");
    run(1, 16'd17, 16'hFFFB, 16'hFFFD, 16'h0002, 1'b0, 1'b0, 18,
        "s 17/-5");
    run(1, 16'hFFEC, 16'hFFFA, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 18,
        "s -20/-6");
    run(1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18,
        "s min/-1");
    run(1, 16'hFFEF, 16'h0000, 16'hFFFF, 16'hFFEF, 1'b1, 1'b0, 1,
        "s -17/0");
    run(1, 16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 1'b0, 18, "s 20/4");

    repeat (4) @(negedge clk);
    chk("u0 scoreboard drained", 32'(sb0.size()), 32'(0));
    chk("u1 scoreboard drained", 32'(sb1.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
- Parametrised multi-cycle restoring integer divider.
- Next generation of the 16-bit sequential divider that drives the LED board.
- Adds configurable width, signed/unsigned mode, a remainder output, divide-by-zero and overflow flags, and a busy/done handshake.
- Sits between the board control FSM (which supplies start and operands) and the display/LED logic (which consumes quotient, remainder and flags).

Parameters:
- WIDTH, 16: operand and result width in bits; legal range 4..32.
- SIGNED, 0: 0 = unsigned division; 1 = two's-complement division.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on the accepted start.
- divisor  input  WIDTH  denominator; captured on the accepted start.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  single-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  divisor was 0; held with the results.
- overflow  output  1  signed MIN / -1 case; held with the results.

Behaviour:
- Reset: rst low forces state IDLE and drives busy, done, quotient, remainder, div_by_zero and overflow to 0, immediately and regardless of clk.
- Reset mid-operation aborts the division. No done pulse is produced for the aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches the operands and captures signs (SIGNED=1), then converts both operands to magnitudes.
  - Clears the flags, loads the iteration counter with WIDTH-1 and moves to CALC.
  - If divisor==0, moves to DONE instead.
- CALC: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude.
  - Set the quotient bit if the result is non-negative.
  - The counter decrements each cycle; exactly WIDTH cycles are spent in CALC; moves to FIX when the counter reaches 0.
  - Partial remainder register is WIDTH+1 bits wide, so the subtract never loses a carry.
- FIX (one cycle), SIGNED=1:
  - Negate the quotient if the operand signs differ (truncation toward zero).
  - Negate the remainder if the dividend was negative (remainder takes the dividend's sign).
  - SIGNED=0: FIX is a pass-through.
- DONE (one cycle): done=1, busy=0, outputs updated; returns to IDLE next cycle.
- Latency: start accepted at edge N gives done high in cycle N+WIDTH+2 (18 cycles for WIDTH=16).
- Divide by zero: done at cycle N+1; quotient = all ones; remainder = dividend as given; div_by_zero=1; busy never asserts.
- Signed overflow (SIGNED=1, dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1), remainder = 0, overflow=1, normal latency.
- start while busy, or in the DONE cycle: ignored, with no effect on the running operation. start held high continuously: a new operation is accepted on each return to IDLE.
- Operand inputs may change freely after the accepted start.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if the divisor is non-zero and |dividend| < |divisor|, skip CALC and FIX.
  - Go straight to DONE with quotient=0 and remainder=dividend, so done arrives at cycle N+1.
  - All other cases keep normal latency.
- Undefined: every non-zero-divisor operation takes the full N+WIDTH+2 latency. Results are identical either way; only latency differs.

Test Plan:
- WIDTH=16, SIGNED=0: 1000 / 7 -> quotient=142, remainder=6, done exactly 18 cycles after start, busy high for cycles 1..17.
- SIGNED=1: -17 / 5 -> quotient=-3 (0xFFFD), remainder=-2 (0xFFFE); 17 / -5 -> quotient=-3, remainder=2.
- Divisor 0 with dividend 0x1234 -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1, done at cycle 1; next start 20/4 clears the flag and gives 5 r 0.
- SIGNED=1: 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0, overflow=1; unsigned 0xFFFF / 0xFFFF -> 1 r 0, flags 0.
- Pulse start again at cycle 5 of 50/3 with operands 9/9 -> ignored, result 16 r 2. Assert rst at cycle 8 of a new op -> all outputs 0 at once, no done, next op correct.
- DIV_EARLY_EXIT_EN defined: 3 / 10 -> quotient 0, remainder 3, done at cycle 1. Undefined: same result at cycle 18.
